// File: rtl/bcd_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter_n
// Purpose  : DIGITS-stage packed-BCD up/down counter with clear, validated
//            load and wrap/saturate behaviour at the terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_counter_n #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    output logic [4*DIGITS-1:0]   count,
    output logic                  ovf,
    output logic                  load_err,
    output logic                  zero
);

    localparam int         c_width = 4 * DIGITS;
    localparam logic [3:0] c_nine  = 4'd9;
    localparam logic [3:0] c_zero  = 4'd0;

    logic [c_width-1:0] r_count;
    logic               r_ovf;
    logic               r_load_err;

    logic [DIGITS-1:0]  w_is_nine;
    logic [DIGITS-1:0]  w_is_zero;
    logic [DIGITS:0]    w_carry;
    logic [DIGITS:0]    w_borrow;
    logic [DIGITS-1:0]  w_bad_digit;
    logic [c_width-1:0] w_inc;
    logic [c_width-1:0] w_dec;
    logic [c_width-1:0] w_clamped;
    logic               w_term_up;
    logic               w_term_dn;

    // Digit k sees a carry (borrow) only when every lower digit is 9 (0),
    // so the whole chain resolves combinationally in one cycle.
    always_comb begin
        w_carry[0]  = 1'b1;
        w_borrow[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            w_carry[k+1]  = w_carry[k]  & w_is_nine[k];
            w_borrow[k+1] = w_borrow[k] & w_is_zero[k];
        end
    end

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            logic [3:0] w_cur;
            logic [3:0] w_din;

            assign w_cur          = r_count[4*k +: 4];
            assign w_din          = din[4*k +: 4];
            assign w_is_nine[k]   = (w_cur == c_nine);
            assign w_is_zero[k]   = (w_cur == c_zero);
            assign w_bad_digit[k] = (w_din > c_nine);

            assign w_inc[4*k +: 4] = !w_carry[k]   ? w_cur :
                                     w_is_nine[k]  ? c_zero : (w_cur + 4'd1);
            assign w_dec[4*k +: 4] = !w_borrow[k]  ? w_cur :
                                     w_is_zero[k]  ? c_nine : (w_cur - 4'd1);
            assign w_clamped[4*k +: 4] = w_bad_digit[k] ? c_nine : w_din;
        end
    endgenerate

    assign w_term_up = w_carry[DIGITS];
    assign w_term_dn = w_borrow[DIGITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_load_err <= 1'b0;
        end else if (clr) begin
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_load_err <= 1'b0;
        end else if (load) begin
            r_count    <= w_clamped;
            r_ovf      <= 1'b0;
            r_load_err <= |w_bad_digit;
        end else if (en) begin
            r_load_err <= 1'b0;
            if (up) begin
                r_ovf <= w_term_up;
                // Wrapping from all 9s is just the natural carry-out result.
                if (!(SATURATE && w_term_up)) begin
                    r_count <= w_inc;
                end
            end else begin
                r_ovf <= w_term_dn;
                if (!(SATURATE && w_term_dn)) begin
                    r_count <= w_dec;
                end
            end
        end else begin
            r_ovf      <= 1'b0;
            r_load_err <= 1'b0;
        end
    end

    assign count    = r_count;
    assign ovf      = r_ovf;
    assign load_err = r_load_err;
    assign zero     = (r_count == '0);

endmodule
`default_nettype wire
